// File: rtl/srt_pkg.sv
// -----------------------------------------------------------------------------
// srt_pkg
// Shared definitions for the radix-4 SRT quotient conversion path:
//   - state_e    : converter FSM states
//   - DIG_*      : legal 3-bit two's-complement quotient digit codes (-2..+2)
//   - QW_DEFAULT : default quotient width in bits
// -----------------------------------------------------------------------------
package srt_pkg;

    localparam int QW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        CORRECT = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [2:0] DIG_P2 = 3'b010;
    localparam logic [2:0] DIG_P1 = 3'b001;
    localparam logic [2:0] DIG_Z  = 3'b000;
    localparam logic [2:0] DIG_M1 = 3'b111;
    localparam logic [2:0] DIG_M2 = 3'b110;

endpackage

// File: rtl/srt_otf_step.sv
// -----------------------------------------------------------------------------
// srt_otf_step
// One on-the-fly conversion step (radix 4). Given the running quotient Q,
// its companion QM = Q - 1, and the next signed digit, produces the next
// Q/QM pair without a carry-propagate adder on the Q path: every new value
// is a 2-bit left shift of Q or QM with a small constant folded into the
// vacated low bits (the synthesiser reduces the adds to that).
// Ports:
//   q_i, qm_i  : current Q and QM (modulo 2^QW)
//   digit_i    : 3-bit two's-complement digit (codes 3 / -4 decode by the
//                same equations)
//   q_o, qm_o  : next Q and QM
// -----------------------------------------------------------------------------
module srt_otf_step
    import srt_pkg::*;
#(
    parameter int QW = QW_DEFAULT
) (
    input  logic [QW-1:0] q_i,
    input  logic [QW-1:0] qm_i,
    input  logic [2:0]    digit_i,
    output logic [QW-1:0] q_o,
    output logic [QW-1:0] qm_o
);

    logic [QW-1:0] d_ext;
    logic [QW-1:0] q_sh;
    logic [QW-1:0] qm_sh;

    assign d_ext = {{(QW-3){digit_i[2]}}, digit_i};
    assign q_sh  = {q_i[QW-3:0], 2'b00};
    assign qm_sh = {qm_i[QW-3:0], 2'b00};

    always_comb begin
        // zero digit
        q_o  = q_sh;
        qm_o = qm_sh + QW'(3);
        if (digit_i[2]) begin
            // negative digit: borrow from the QM form
            q_o  = qm_sh + QW'(4) + d_ext;
            qm_o = qm_sh + QW'(3) + d_ext;
        end else if (digit_i != DIG_Z) begin
            q_o  = q_sh + d_ext;
            qm_o = q_sh + d_ext - QW'(1);
        end
    end

endmodule

// File: rtl/srt_quotient_converter.sv
// -----------------------------------------------------------------------------
// srt_quotient_converter
// Accepts N = QW/2 radix-4 redundant quotient digits over a valid/ready
// handshake, converts them on the fly into a binary quotient, optionally
// applies the final-remainder sign correction (Q or Q-1), and presents the
// result with a one-cycle done pulse.
//
// Build option: SRT_QCONV_REM_FIX_EN
//   defined     - CORRECT state waits for rem_valid, quotient = rem_neg ? QM : Q
//   not defined - CORRECT skipped, quotient = Q, rem_valid/rem_neg ignored
//
// Ports:
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : begin a conversion (IDLE only)
//   digit_valid  : q_digit valid
//   q_digit      : signed digit -2..+2
//   digit_ready  : digit accepted this cycle when high with digit_valid
//   rem_valid    : rem_neg valid
//   rem_neg      : final partial remainder negative
//   busy         : conversion in progress (ACCUM / CORRECT)
//   done         : one-cycle pulse, quotient valid
//   quotient     : result, held until overwritten by the next conversion
// -----------------------------------------------------------------------------
module srt_quotient_converter
    import srt_pkg::*;
#(
    parameter int QW = QW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          digit_valid,
    input  logic [2:0]    q_digit,
    output logic          digit_ready,
    input  logic          rem_valid,
    input  logic          rem_neg,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int N  = QW / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e        state_q;
    logic [QW-1:0] q_q, qm_q;
    logic [QW-1:0] q_d, qm_d;
    logic [CW-1:0] cnt_q;
    logic [QW-1:0] quotient_q;
    logic          busy_q, done_q, ready_q;

`ifndef SRT_QCONV_REM_FIX_EN
    logic unused_rem;
    assign unused_rem = rem_valid ^ rem_neg;
`endif

    srt_otf_step #(.QW(QW)) u_step (
        .q_i     (q_q),
        .qm_i    (qm_q),
        .digit_i (q_digit),
        .q_o     (q_d),
        .qm_o    (qm_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            q_q        <= '0;
            qm_q       <= '0;
            cnt_q      <= '0;
            quotient_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        q_q     <= '0;
                        qm_q    <= '1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (digit_valid) begin
                        q_q   <= q_d;
                        qm_q  <= qm_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) begin
                            ready_q <= 1'b0;
`ifdef SRT_QCONV_REM_FIX_EN
                            state_q <= CORRECT;
`else
                            quotient_q <= q_d;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
`endif
                        end
                    end
                end
                CORRECT: begin
`ifdef SRT_QCONV_REM_FIX_EN
                    if (rem_valid) begin
                        quotient_q <= rem_neg ? qm_q : q_q;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
`else
                    // unreachable without the correction option
                    state_q <= IDLE;
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign digit_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;

endmodule

// File: tb/tb_srt_quotient_converter.sv
// -----------------------------------------------------------------------------
// tb_srt_quotient_converter
// Drives digit sequences (directed and random) and checks busy, digit_ready,
// done and quotient every cycle against expectations derived from the digit
// values (sum of d_i * 4^(N-1-i), modulo 2^QW, minus one ulp on a negative
// remainder when the correction option is built in) and from the documented
// handshake timing.
// -----------------------------------------------------------------------------
module tb_srt_quotient_converter;
    import srt_pkg::*;

    localparam int QW = 8;
    localparam int N  = QW / 2;

    logic          clk = 1'b0;
    logic          rst, start, digit_valid, rem_valid, rem_neg;
    logic [2:0]    q_digit;
    logic          digit_ready, busy, done;
    logic [QW-1:0] quotient;

    always #5 clk = ~clk;

    srt_quotient_converter #(.QW(QW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .digit_valid (digit_valid),
        .q_digit     (q_digit),
        .digit_ready (digit_ready),
        .rem_valid   (rem_valid),
        .rem_neg     (rem_neg),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient)
    );

    int            n_cmp = 0;
    int            n_bad = 0;
    logic          chk_en    = 1'b0;
    logic          exp_busy  = 1'b0;
    logic          exp_ready = 1'b0;
    logic          exp_done  = 1'b0;
    logic [QW-1:0] exp_quot  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",        32'(busy),        32'(exp_busy));
            chk("digit_ready", 32'(digit_ready), 32'(exp_ready));
            chk("done",        32'(done),        32'(exp_done));
            chk("quotient",    32'(quotient),    32'(exp_quot));
        end
    end

    // plain arithmetic value of the digit string
    function automatic logic [QW-1:0] model(input logic [2:0] d[N]);
        longint acc = 0;
        for (int i = 0; i < N; i++)
            acc = acc * 4 + (d[i][2] ? longint'(d[i]) - 8 : longint'(d[i]));
        return acc[QW-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] d[N], input int gap, input int rem_dly,
                       input logic rn, input bit mid_start);
        logic [QW-1:0] v;
        v = model(d);
        start = 1'b1;
        step();
        start     = 1'b0;
        exp_busy  = 1'b1;
        exp_ready = 1'b1;
        // remainder info offered early must be ignored in ACCUM
        rem_valid = 1'b1;
        rem_neg   = ~rn;
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) begin
                digit_valid = 1'b0;
                q_digit     = 3'($urandom);
                step();
            end
            digit_valid = 1'b1;
            q_digit     = d[i];
            start       = mid_start && (i == 1);
            step();
            digit_valid = 1'b0;
            start       = 1'b0;
        end
`ifdef SRT_QCONV_REM_FIX_EN
        exp_ready = 1'b0;
        rem_valid = 1'b0;
        for (int g = 0; g < rem_dly; g++) step();
        rem_valid = 1'b1;
        rem_neg   = rn;
        step();
        rem_valid = 1'b0;
        exp_quot  = rn ? v - 1'b1 : v;
`else
        rem_valid = 1'b0;
        exp_quot  = v;
`endif
        exp_busy  = 1'b0;
        exp_ready = 1'b0;
        exp_done  = 1'b1;
        step();
        exp_done = 1'b0;
`ifndef SRT_QCONV_REM_FIX_EN
        for (int g = 0; g < rem_dly; g++) step();
`endif
    endtask

    logic [2:0] tp[N];
    logic [2:0] rd[N];

    initial begin
        rst = 1'b1; start = 1'b0; digit_valid = 1'b0; q_digit = '0;
        rem_valid = 1'b0; rem_neg = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset_quotient", 32'(quotient), 32'h0);
        chk("reset_busy",     32'(busy),     32'h0);

        // digits outside ACCUM are not accepted
        digit_valid = 1'b1; q_digit = DIG_P2;
        step();
        digit_valid = 1'b0;

        tp = '{DIG_P1, DIG_P2, DIG_Z, DIG_M1};
        run(tp, 0, 0, 1'b0, 1'b0);
        chk("lit_p1p2z_m1", 32'(quotient), 32'h5F);
        run(tp, 0, 0, 1'b1, 1'b0);
`ifdef SRT_QCONV_REM_FIX_EN
        chk("lit_remneg", 32'(quotient), 32'h5E);
`else
        chk("lit_remneg", 32'(quotient), 32'h5F);
`endif
        rd = '{DIG_P2, DIG_P2, DIG_P2, DIG_P2};
        run(rd, 0, 0, 1'b0, 1'b0);
        chk("lit_all_p2", 32'(quotient), 32'hAA);
        rd = '{DIG_M2, DIG_M2, DIG_M2, DIG_M2};
        run(rd, 0, 0, 1'b0, 1'b0);
        chk("lit_all_m2", 32'(quotient), 32'h56);
        run(tp, 2, 5, 1'b0, 1'b0);
        chk("lit_stalled", 32'(quotient), 32'h5F);
        run(tp, 1, 0, 1'b0, 1'b1);
        chk("lit_mid_start", 32'(quotient), 32'h5F);

        // reset after two digits
        start = 1'b1;
        step();
        start = 1'b0; exp_busy = 1'b1; exp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            digit_valid = 1'b1; q_digit = DIG_P2;
            step();
        end
        digit_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_busy = 1'b0; exp_ready = 1'b0; exp_done = 1'b0; exp_quot = '0;
        step();
        run(tp, 0, 0, 1'b0, 1'b0);
        chk("lit_after_rst", 32'(quotient), 32'h5F);

        // random digit strings, including the two illegal codes
        repeat (40) begin
            for (int i = 0; i < N; i++) rd[i] = 3'($urandom_range(0, 7));
            run(rd, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom));
        end

        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/srt_quotient_converter.md
# srt_quotient_converter

Downstream stage of the radix-4 SRT quotient selector. It consumes the selector's per-iteration redundant quotient digits (-2..+2) through a valid/ready handshake and converts them on the fly into a conventional binary quotient, with no carry-propagate adder. After the last digit it applies the final-remainder sign correction (Q or Q-1 ulp), then presents the quotient with a one-cycle done pulse.

## Interface
- QW, 8: quotient width in bits; even, >= 4; digits per division N = QW/2
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin new conversion; honoured only in IDLE
- digit_valid  input  1  q_digit holds a digit
- q_digit  input  3  signed two's-complement digit, legal -2..+2
- digit_ready  output  1  high in ACCUM only
- rem_valid  input  1  rem_neg is valid (final remainder sign)
- rem_neg  input  1  final partial remainder is negative
- busy  output  1  high in ACCUM and CORRECT
- done  output  1  one-cycle pulse, quotient valid
- quotient  output  QW  converted quotient, held until next start

## Operation
- States: IDLE, ACCUM, CORRECT, DONE.
- IDLE, start=1: Q<=0, QM<=all ones (-1 mod 2^QW), cnt<=0, go to ACCUM.
- ACCUM, digit_valid & digit_ready: update registers with digit q, cnt++:
  - q>0: Q<=4Q+q, QM<=4Q+q-1
  - q=0: Q<=4Q, QM<=4QM+3
  - q<0: Q<=4QM+4+q, QM<=4QM+3+q
- All arithmetic is modulo 2^QW; the 2 bits shifted out are discarded.
- ACCUM leaves for CORRECT when the N-th digit is accepted (cnt == N-1 at acceptance).
- CORRECT, rem_valid=1: quotient<=rem_neg ? QM : Q, go to DONE. rem_valid=0: wait indefinitely.
- DONE: done=1 for exactly one cycle, then IDLE. quotient holds its value.
- start outside IDLE is ignored. digit_valid outside ACCUM is ignored (no acceptance). rem_valid outside CORRECT is ignored.
- Illegal digit codes (3'b011 = +3, 3'b100 = -4) are decoded by the same equations. No error is flagged; the selector never produces them.
- rst in any state: next state IDLE; Q, QM, cnt, quotient = 0; busy, done, digit_ready = 0.

## Timing
- Reset values: quotient=0, done=0, busy=0, digit_ready=0.
- start sampled at edge k makes busy=1 and digit_ready=1 from cycle k+1.
- One digit per cycle at full throughput; stalls on digit_valid=0 add cycles without changing the result.
- With rem_valid already high: last digit accepted at edge t, CORRECT during t+1, DONE (done=1, quotient valid) during t+2.
- Minimum start-to-done is N+2 cycles. The next start is accepted in the cycle after DONE.

## Configuration
- SRT_QCONV_REM_FIX_EN defined: CORRECT state and rem_valid/rem_neg used as above.
- Not defined: CORRECT is skipped. quotient<=Q on the N-th digit and DONE follows directly (N+1 cycles). rem_valid/rem_neg ports remain but are ignored, and QM logic may be optimised away.

## Structure
- Shared package srt_pkg holds:
  - state enum (IDLE, ACCUM, CORRECT, DONE)
  - digit constants DIG_P2..DIG_M2
  - default QW
- One natural sub-module, srt_otf_step: combinational next Q/QM from (Q, QM, q_digit). It is reusable by a future radix-2 variant.

## Test plan
- QW=8, digits +1,+2,0,-1, rem_neg=0 -> quotient=0x5F, done one cycle at N+2 after start.
- Same digits, rem_neg=1 -> quotient=0x5E.
- Digits +2,+2,+2,+2, rem_neg=0 -> 0xAA. Digits -2,-2,-2,-2, rem_neg=0 -> 0x56 (mod 256).
- Digits with digit_valid gaps (valid every 3rd cycle) and rem_valid delayed 5 cycles -> same 0x5F; busy high throughout; digit_ready low in CORRECT.
- start pulsed mid-ACCUM -> ignored, result unchanged. rst after 2 digits -> IDLE, all outputs 0; new run gives correct value.
- SRT_QCONV_REM_FIX_EN undefined, digits +1,+2,0,-1, rem_neg=1 -> quotient=0x5F, done at N+1 after start.
